// File: rtl/io_sched_pkg.sv
// rtl/io_sched_pkg.sv - shared state type, STOP code and command-code decode for io_dev_sched
package io_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4
  } sched_state_e;

  localparam int         DEV_IDX_W = 2;
  localparam logic [4:0] STOP_CODE = 5'b10000;

  typedef struct packed {
    logic                 valid;
    logic [DEV_IDX_W-1:0] idx;
  } oc_dec_t;

  // 0100 typewriter, 0101 phototape, 0110 card, 0111 mag tape; all else invalid
  function automatic oc_dec_t oc_to_dev(input logic [3:0] oc);
    oc_dec_t d;
    d.valid = 1'b0;
    d.idx   = '0;
    case (oc)
      4'b0100: begin d.valid = 1'b1; d.idx = 2'd0; end
      4'b0101: begin d.valid = 1'b1; d.idx = 2'd1; end
      4'b0110: begin d.valid = 1'b1; d.idx = 2'd2; end
      4'b0111: begin d.valid = 1'b1; d.idx = 2'd3; end
      default: begin d.valid = 1'b0; d.idx = '0;   end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/io_sched_tmo.sv
// rtl/io_sched_tmo.sv - saturating word-time counter with synchronous clear and expire flag
module io_sched_tmo #(
  parameter int TIMEOUT_WT = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping so a long stall can never look fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt >= CNT_W'(TIMEOUT_WT));

endmodule

// File: rtl/io_dev_sched.sv
// rtl/io_dev_sched.sv - I/O device scheduler: decodes OC, grants one bridge, moves one char per word time
// Optional timeout path enabled by defining G15_IO_SCHED_TIMEOUT_EN.
module io_dev_sched
  import io_sched_pkg::*;
#(
  parameter int NDEV       = 4,
  parameter int CHAR_W     = 5,
  parameter int TIMEOUT_WT = 16
) (
  input  logic                   CLOCK,
  input  logic                   rst_n,
  input  logic                   T0,
  input  logic                   cmd_valid,
  input  logic [3:0]             OC,
  input  logic [NDEV-1:0]        dev_req,
  input  logic [NDEV*CHAR_W-1:0] dev_char,
  input  logic                   char_taken,
  output logic [NDEV-1:0]        grant,
  output logic [NDEV-1:0]        dev_ack,
  output logic [CHAR_W-1:0]      char_out,
  output logic                   char_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic                 r_cmd_d;
  logic [DEV_IDX_W-1:0] r_sel;
  logic [CHAR_W-1:0]    r_char;
  logic                 r_err;

  oc_dec_t              w_dec;
  logic                 w_rise;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_err_set;
  logic                 w_err_clr;
  logic                 w_expire;
  logic                 w_req_sel;
  logic [CHAR_W-1:0]    w_char_sel;
  logic [NDEV-1:0]      w_sel_oh;
  logic                 w_granted;

  assign w_dec      = oc_to_dev(OC);
  assign w_rise     = cmd_valid && !r_cmd_d;
  assign w_req_sel  = dev_req[r_sel];
  assign w_char_sel = dev_char[int'(r_sel)*CHAR_W +: CHAR_W];
  assign w_sel_oh   = {{(NDEV-1){1'b0}}, 1'b1} << r_sel;

`ifdef G15_IO_SCHED_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_tmo_inc;

  // Only missed word times inside WAIT count; any other state restarts the count
  assign w_tmo_clr = (r_state != WAIT);
  assign w_tmo_inc = (r_state == WAIT) && T0 && !w_req_sel;

  io_sched_tmo #(
    .TIMEOUT_WT(TIMEOUT_WT),
    .CNT_W     (8)
  ) u_tmo (
    .clk     (CLOCK),
    .rst_n   (rst_n),
    .i_clr   (w_tmo_clr),
    .i_inc   (w_tmo_inc),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cmd_d <= 1'b0;
      r_sel   <= '0;
      r_char  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd_d <= cmd_valid;
      if (w_load) begin
        r_sel <= w_dec.idx;
      end
      if (w_capture) begin
        r_char <= w_char_sel;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Abort (cmd_valid low) outranks everything except a same-cycle char_taken ack
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_err_clr = 1'b1;
          if (w_dec.valid) begin
            w_load      = 1'b1;
            w_state_nxt = ARM;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ARM: begin
        if (!cmd_valid) begin
          w_state_nxt = IDLE;
        end else if (T0) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!cmd_valid) begin
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end else if (T0 && w_req_sel) begin
          w_capture   = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (!cmd_valid) begin
          w_state_nxt = IDLE;
        end else if (char_taken) begin
          w_state_nxt = (r_char == CHAR_W'(STOP_CODE)) ? DONE : WAIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_granted  = (r_state == ARM) || (r_state == WAIT) || (r_state == XFER);
  assign grant      = w_granted ? w_sel_oh : '0;
  assign dev_ack    = ((r_state == XFER) && char_taken) ? w_sel_oh : '0;
  assign char_out   = r_char;
  assign char_valid = (r_state == XFER);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign err        = r_err;

endmodule

// File: tb/tb_io_dev_sched.sv
// tb/tb_io_dev_sched.sv - self-checking bench for io_dev_sched: directed cases plus randomized traffic vs model
module tb_io_dev_sched;

  localparam int NDEV = 4;
  localparam int CW   = 5;
  localparam int TWT  = 16;
`ifdef G15_IO_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 CLOCK      = 1'b0;
  logic                 rst_n      = 1'b0;
  logic                 T0         = 1'b0;
  logic                 cmd_valid  = 1'b0;
  logic                 char_taken = 1'b0;
  logic [3:0]           OC         = '0;
  logic [NDEV-1:0]      dev_req    = '0;
  logic [NDEV*CW-1:0]   dev_char   = '0;
  logic [NDEV-1:0]      grant;
  logic [NDEV-1:0]      dev_ack;
  logic [CW-1:0]        char_out;
  logic                 char_valid;
  logic                 busy;
  logic                 done;
  logic                 err;

  int n_checks = 0;
  int n_errors = 0;

  io_dev_sched #(.NDEV(NDEV), .CHAR_W(CW), .TIMEOUT_WT(TWT)) dut (
    .CLOCK     (CLOCK),
    .rst_n     (rst_n),
    .T0        (T0),
    .cmd_valid (cmd_valid),
    .OC        (OC),
    .dev_req   (dev_req),
    .dev_char  (dev_char),
    .char_taken(char_taken),
    .grant     (grant),
    .dev_ack   (dev_ack),
    .char_out  (char_out),
    .char_valid(char_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLOCK = ~CLOCK;

  // Word time = 4 clocks
  int t0_phase = 0;
  initial forever begin
    @(posedge CLOCK);
    #1;
    t0_phase = (t0_phase + 1) % 4;
    T0 = (t0_phase == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: command in progress, char held, finishing, missed word times
  bit            m_active, m_armed, m_have, m_finish, m_err, m_prev_cmd;
  int            m_dev, m_miss;
  logic [CW-1:0] m_char;
  int            t0_count = 0;
  bit            last_t0  = 1'b0;

  always @(posedge CLOCK) begin
    t0_count += int'(T0);
    last_t0 = T0;
  end

  always @(posedge CLOCK or negedge rst_n) begin : model
    bit rise;
    if (!rst_n) begin
      m_active = 0; m_armed = 0; m_have = 0; m_finish = 0; m_err = 0; m_prev_cmd = 0;
      m_dev = 0; m_miss = 0; m_char = '0;
    end else begin
      rise = cmd_valid && !m_prev_cmd;
      if (m_finish) begin
        m_finish = 0;
        m_active = 0;
      end else if (!m_active) begin
        if (rise) begin
          m_err = 0;
          if (OC >= 4'd4 && OC <= 4'd7) begin
            m_active = 1; m_armed = 1; m_have = 0; m_dev = int'(OC) - 4;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_have) begin
        if (char_taken) begin
          m_have = 0;
          if (!cmd_valid) m_active = 0;
          else if (m_char == 5'h10) m_finish = 1;
          else m_miss = 0;
        end else if (!cmd_valid) begin
          m_have = 0;
          m_active = 0;
        end
      end else if (!cmd_valid) begin
        m_active = 0;
      end else if (m_armed) begin
        if (T0) begin m_armed = 0; m_miss = 0; end
      end else if (TMO_EN && m_miss >= TWT) begin
        m_err = 1;
        m_active = 0;
      end else if (T0 && dev_req[m_dev]) begin
        m_char = dev_char[m_dev*CW +: CW];
        m_have = 1;
      end else if (T0) begin
        m_miss++;
      end
      m_prev_cmd = cmd_valid;
    end
  end

  always @(negedge CLOCK) begin : compare
    logic [NDEV-1:0] oh;
    oh = m_active ? (NDEV'(1) << m_dev) : '0;
    check("busy",       busy,       m_active);
    check("grant",      grant,      (m_active && !m_finish) ? oh : '0);
    check("char_valid", char_valid, m_have);
    check("char_out",   char_out,   m_char);
    check("dev_ack",    dev_ack,    (m_have && char_taken) ? oh : '0);
    check("done",       done,       m_finish);
    check("err",        err,        m_err);
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Returns at the first negedge showing char_valid; that char must follow a T0 edge
  task automatic wait_cv(input string name);
    for (int k = 0; k < 64; k++) begin
      @(negedge CLOCK);
      if (char_valid) break;
    end
    check({name, "_cv_seen"}, char_valid, 1'b1);
    check({name, "_after_t0"}, last_t0, 1'b1);
  endtask

  initial begin
    int t0_start;
    step(); step();
    @(negedge CLOCK);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_cv", char_valid, 0);
    check("rst_char", char_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    step(); rst_n = 1'b1;

    // Basic transfer from phototape; other devices request but are ignored
    step(); OC = 4'b0101; cmd_valid = 1'b1; dev_char = {5'h1f, 5'h1e, 5'h03, 5'h1d};
    step(); @(negedge CLOCK);
    check("t1_grant", grant, 4'b0010);
    check("t1_busy", busy, 1);
    step(); dev_req = 4'b1101;
    repeat (8) step();
    @(negedge CLOCK);
    check("t1_ignore_other", char_valid, 0);
    step(); dev_req = 4'b0010;
    wait_cv("t1");
    check("t1_char", char_out, 5'h03);
    step(); dev_req = '0; char_taken = 1'b1;
    @(negedge CLOCK);
    check("t1_ack", dev_ack, 4'b0010);
    step(); char_taken = 1'b0;
    @(negedge CLOCK);
    check("t1_back_wait", char_valid, 0);
    check("t1_still_busy", busy, 1);

    // STOP code finishes the command
    step(); dev_char[9:5] = 5'h10; dev_req = 4'b0010;
    wait_cv("t2");
    check("t2_char", char_out, 5'h10);
    step(); dev_req = '0; char_taken = 1'b1;
    @(negedge CLOCK);
    check("t2_ack", dev_ack, 4'b0010);
    step(); char_taken = 1'b0;
    @(negedge CLOCK);
    check("t2_done", done, 1);
    check("t2_grant_done", grant, 0);
    step(); @(negedge CLOCK);
    check("t2_done_once", done, 0);
    check("t2_idle", busy, 0);
    check("t2_grant_after", grant, 0);

    // Bad command, then a good one clears err
    step(); cmd_valid = 1'b0;
    step(); OC = 4'b1111; cmd_valid = 1'b1;
    step(); @(negedge CLOCK);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_grant", grant, 0);
    step(); step(); @(negedge CLOCK);
    check("t3_busy_stays", busy, 0);
    step(); cmd_valid = 1'b0;
    step(); OC = 4'b0100; cmd_valid = 1'b1;
    step(); @(negedge CLOCK);
    check("t3_err_clr", err, 0);
    check("t3_grant_tw", grant, 4'b0001);
    t0_start = t0_count;

    // No dev_req: timeout after 1 arming T0 + TWT missed T0s, or wait forever
`ifdef G15_IO_SCHED_TIMEOUT_EN
    for (int k = 0; k < 400; k++) begin
      @(negedge CLOCK);
      if (!busy) break;
    end
    check("t4_idle", busy, 0);
    check("t4_err", err, 1);
    check("t4_t0s", t0_count - t0_start, 1 + TWT);
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLOCK);
      if (t0_count - t0_start >= 101) break;
    end
    check("t4_t0s_seen", (t0_count - t0_start >= 101), 1);
    check("t4_still_busy", busy, 1);
    check("t4_no_err", err, 0);
`endif
    step(); cmd_valid = 1'b0;

    // Abort while a char is held
    step(); OC = 4'b0110; cmd_valid = 1'b1; dev_char[14:10] = 5'h05; dev_req = 4'b0100;
    wait_cv("t5");
    check("t5_char", char_out, 5'h05);
    step(); cmd_valid = 1'b0; dev_req = '0;
    step(); @(negedge CLOCK);
    check("t5_cv", char_valid, 0);
    check("t5_grant", grant, 0);
    check("t5_ack", dev_ack, 0);
    check("t5_done", done, 0);

    // Abort together with char_taken: ack still issued
    step(); cmd_valid = 1'b1; dev_req = 4'b0100;
    wait_cv("t5b");
    step(); cmd_valid = 1'b0; char_taken = 1'b1; dev_req = '0;
    @(negedge CLOCK);
    check("t5b_ack", dev_ack, 4'b0100);
    step(); char_taken = 1'b0;
    @(negedge CLOCK);
    check("t5b_idle", busy, 0);
    check("t5b_done", done, 0);

    // Async reset in WAIT
    step(); OC = 4'b0111; cmd_valid = 1'b1;
    repeat (10) step();
    @(negedge CLOCK);
    check("t6_busy_before", busy, 1);
    #1 rst_n = 1'b0; cmd_valid = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_grant", grant, 0);
    check("t6_char", char_out, 0);
    check("t6_cv", char_valid, 0);
    check("t6_err", err, 0);
    #1 rst_n = 1'b1;

    // Randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!cmd_valid) begin
        OC = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(4, 7));
        if ($urandom_range(0, 2) == 0) cmd_valid = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        cmd_valid = 1'b0;
      end
      dev_req = NDEV'($urandom);
      for (int j = 0; j < NDEV; j++) begin
        dev_char[j*CW +: CW] = ($urandom_range(0, 5) == 0) ? 5'h10 : 5'($urandom);
      end
      char_taken = ($urandom_range(0, 2) != 0);
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
